// File: rtl/interrupt_pkg.sv
// Shared types and constants for the fixed-priority interrupt controller.
package interrupt_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        SERVICE = 2'd2
    } state_e;

    localparam int          NUM_SRC_DEF  = 8;
    localparam logic [7:0]  VEC_BASE_DEF = 8'h20;
    localparam int          IDX_W        = 4;

endpackage

// File: rtl/interrupt_controller_prio_encoder.sv
// Combinational lowest-index-first priority encoder over the pending vector.
module prio_encoder
    import interrupt_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEF
) (
    input  logic [NUM_SRC-1:0] pending_i,
    output logic               valid_o,
    output logic [IDX_W-1:0]   idx_o
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pending_i[i]) begin
                valid_o = 1'b1;
                idx_o   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Fixed-priority interrupt controller: one interrupt in flight, ack/done handshake.
// Optional INT_MASK_EN adds a writable per-source mask register.
module interrupt_controller
    import interrupt_pkg::*;
#(
    parameter int         NUM_SRC  = NUM_SRC_DEF,
    parameter logic [7:0] VEC_BASE = VEC_BASE_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] int_request,
    output logic [NUM_SRC-1:0] int_handled,
    output logic               irq,
    input  logic               int_ack,
    input  logic               int_done,
    output logic [7:0]         int_vector,
    output logic               busy
`ifdef INT_MASK_EN
    ,
    input  logic               mask_we,
    input  logic [NUM_SRC-1:0] mask_wdata,
    output logic [NUM_SRC-1:0] mask_q
`endif
);

    state_e             state_q;
    logic [IDX_W-1:0]   sel_q;
    logic               irq_q;
    logic [7:0]         vec_q;
    logic [NUM_SRC-1:0] handled_q;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] pending;
    logic               win_vld;
    logic [IDX_W-1:0]   win_idx;

`ifdef INT_MASK_EN
    always_ff @(posedge clk) begin
        if (reset)        mask_q <= '1;
        else if (mask_we) mask_q <= mask_wdata;
    end
    assign mask = mask_q;
`else
    assign mask = '1;
`endif

    assign pending = int_request & mask;

    prio_encoder #(.NUM_SRC(NUM_SRC)) u_prio (
        .pending_i (pending),
        .valid_o   (win_vld),
        .idx_o     (win_idx)
    );

    // sel/vector are only loaded in IDLE, so REQUEST never re-arbitrates.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            irq_q     <= 1'b0;
            vec_q     <= '0;
            handled_q <= '0;
        end else begin
            handled_q <= '0;
            case (state_q)
                REQUEST: begin
                    if (int_ack) begin
                        irq_q     <= 1'b0;
                        handled_q <= NUM_SRC'(1) << sel_q;
                        state_q   <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (int_done) state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    if (win_vld) begin
                        sel_q   <= win_idx;
                        vec_q   <= VEC_BASE + {{(8 - IDX_W){1'b0}}, win_idx};
                        irq_q   <= 1'b1;
                        state_q <= REQUEST;
                    end
                end
            endcase
        end
    end

    assign irq         = irq_q;
    assign int_vector  = vec_q;
    assign int_handled = handled_q;
    assign busy        = (state_q == REQUEST) || (state_q == SERVICE);

endmodule

// File: tb/tb_interrupt_controller.sv
// Scoreboard bench: driver pushes expected vector/clear per delivery, monitor pops on irq rise / int_handled pulse.
// Build with INT_MASK_EN defined to also exercise the mask register.
module tb_interrupt_controller;

    localparam int         N    = 8;
    localparam logic [7:0] VB   = 8'h20;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] int_request;
    logic [N-1:0] int_handled;
    logic         irq;
    logic         int_ack;
    logic         int_done;
    logic [7:0]   int_vector;
    logic         busy;
`ifdef INT_MASK_EN
    logic         mask_we;
    logic [N-1:0] mask_wdata;
    logic [N-1:0] mask_q;
`endif

    interrupt_controller #(.NUM_SRC(N), .VEC_BASE(VB)) dut (
        .clk         (clk),
        .reset       (reset),
        .int_request (int_request),
        .int_handled (int_handled),
        .irq         (irq),
        .int_ack     (int_ack),
        .int_done    (int_done),
        .int_vector  (int_vector),
        .busy        (busy)
`ifdef INT_MASK_EN
        ,
        .mask_we     (mask_we),
        .mask_wdata  (mask_wdata),
        .mask_q      (mask_q)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0]   qv[$];
    logic [N-1:0] qh[$];
    logic [N-1:0] P = '0;   // request lines held by the modelled handlers
    int           cur_w;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int lowest(input logic [N-1:0] p);
        for (int i = 0; i < N; i++)
            if (p[i]) return i;
        return -1;
    endfunction

    function automatic logic [N-1:0] rnd();
        logic [31:0] t;
        t = $urandom;
        return t[N-1:0];
    endfunction

    task automatic push_exp();
        cur_w = lowest(P);
        qv.push_back(VB + 8'(cur_w));
        qh.push_back(N'(1) << cur_w);
    endtask

    task automatic wait_irq();
        int n = 0;
        while (!irq && n < 20) begin
            tick();
            n++;
        end
        if (!irq) chk("irq_timeout", 32'(irq), 1);
    endtask

    // Monitor: compares every delivery against the scoreboard queues.
    logic         irq_prev = 1'b0;
    logic [N-1:0] hprev    = '0;
    always @(negedge clk) begin
        if (!reset) begin
            if (irq && !irq_prev) begin
                if (qv.size() == 0) chk("unexpected_irq", 32'(int_vector), 32'hFFFF);
                else chk("vector", 32'(int_vector), 32'(qv.pop_front()));
            end
            if (int_handled != '0) begin
                if (qh.size() == 0) chk("unexpected_handled", 32'(int_handled), 0);
                else chk("handled", 32'(int_handled), 32'(qh.pop_front()));
                chk("irq_low_with_handled", 32'(irq), 0);
                chk("handled_one_cycle", 32'(hprev), 0);
            end
        end
        irq_prev <= irq;
        hprev    <= int_handled;
    end

    initial begin
        reset = 1'b1; int_request = '0; int_ack = 1'b0; int_done = 1'b0;
`ifdef INT_MASK_EN
        mask_we = 1'b0; mask_wdata = '1;
`endif
        tick(); tick();
        chk("rst_irq", 32'(irq), 0);
        chk("rst_handled", 32'(int_handled), 0);
        chk("rst_vector", 32'(int_vector), 0);
        chk("rst_busy", 32'(busy), 0);
        reset = 1'b0;

        // Stray ack in IDLE, then a single source with stray done in REQUEST.
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        chk("ack_idle_busy", 32'(busy), 0);
        chk("ack_idle_handled", 32'(int_handled), 0);
        P = 8'h08; int_request = P; push_exp();
        tick();
        chk("single_irq_latency", 32'(irq), 1);
        chk("single_vector", 32'(int_vector), 32'h23);
        int_done = 1'b1; tick(); int_done = 1'b0;
        chk("done_in_request_irq", 32'(irq), 1);
        chk("done_in_request_busy", 32'(busy), 1);
        int_ack = 1'b1; int_done = 1'b1; tick(); int_ack = 1'b0; int_done = 1'b0;
        chk("ack_irq_low", 32'(irq), 0);
        chk("ack_handled", 32'(int_handled), 32'h08);
        P = '0; int_request = P;
        tick();
        chk("handled_cleared", 32'(int_handled), 0);
        chk("service_busy", 32'(busy), 1);
        int_done = 1'b1; tick(); int_done = 1'b0;
        chk("done_busy", 32'(busy), 0);

        // Randomised rounds; new requests stop after round 40 so the backlog drains.
        for (int r = 0; r < 80 && !(r >= 40 && P == '0); r++) begin
            if (P == '0) begin
                while (P == '0) P = rnd();
                int_request = P;
                push_exp();
            end
            wait_irq();
            chk("busy_request", 32'(busy), 1);
            repeat ($urandom_range(0, 3)) begin
                if (r < 40 && $urandom_range(0, 1) == 1) begin P |= rnd(); int_request = P; end
                if ($urandom_range(0, 3) == 0) int_done = 1'b1;
                tick(); int_done = 1'b0;
                chk("request_held", 32'(irq), 1);
            end
            int_ack = 1'b1; tick(); int_ack = 1'b0;
            P[cur_w] = 1'b0; int_request = P;
            repeat ($urandom_range(0, 3)) begin
                if (r < 40 && $urandom_range(0, 1) == 1) begin P |= rnd(); int_request = P; end
                if ($urandom_range(0, 2) == 0) int_ack = 1'b1;
                tick(); int_ack = 1'b0;
                chk("service_no_irq", 32'(irq), 0);
            end
            int_done = 1'b1; tick(); int_done = 1'b0;
            chk("idle_after_done", 32'(busy), 0);
            chk("irq_low_after_done", 32'(irq), 0);
            if (P != '0) begin
                push_exp();
                tick();
                chk("b2b_irq", 32'(irq), 1);
            end
        end

        // Reset in SERVICE while int_handled is high; source 6 stays pending.
        P = 8'h44; int_request = P; push_exp();
        wait_irq();
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        chk("rst_test_handled", 32'(int_handled), 32'h04);
        if (qh.size() != 0) void'(qh.pop_front());
        P[2] = 1'b0; int_request = P;
        reset = 1'b1; tick();
        chk("midrst_irq", 32'(irq), 0);
        chk("midrst_handled", 32'(int_handled), 0);
        chk("midrst_vector", 32'(int_vector), 0);
        chk("midrst_busy", 32'(busy), 0);
        reset = 1'b0; push_exp();
        tick();
        chk("rearb_irq", 32'(irq), 1);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        P = '0; int_request = P;
        int_done = 1'b1; tick(); int_done = 1'b0;

`ifdef INT_MASK_EN
        chk("mask_reset", 32'(mask_q), 32'hFF);
        mask_we = 1'b1; mask_wdata = 8'hFD; tick(); mask_we = 1'b0;
        P = 8'h02; int_request = P;
        repeat (4) begin
            tick();
            chk("masked_no_irq", 32'(irq), 0);
        end
        mask_we = 1'b1; mask_wdata = 8'hFF; tick(); mask_we = 1'b0;
        push_exp();
        chk("unmask_edge_no_irq", 32'(irq), 0);
        tick();
        chk("unmask_irq", 32'(irq), 1);
        chk("unmask_vector", 32'(int_vector), 32'h21);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        P = '0; int_request = P;
        int_done = 1'b1; tick(); int_done = 1'b0;
`endif

        tick(); tick();
        chk("queue_drain", 32'(qv.size() + qh.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
Consumes the per-source int_request lines produced by the edge-latching interrupt handler instances and arbitrates among them with fixed priority. Presents one interrupt at a time to the CPU with a vector. On CPU acknowledge, pulses the matching int_handled back to the winning handler to clear its request. Sits between the handler bank and the CPU core's interrupt entry/return logic.

Parameters:
NUM_SRC, 8, number of interrupt sources; legal range 1..16.
VEC_BASE, 8'h20, vector for source 0; the vector for source i is VEC_BASE+i, 8-bit wrap-around.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
int_request  in  NUM_SRC  level request per source, from the handlers.
int_handled  out  NUM_SRC  one-cycle clear pulse per source, back to the handlers.
irq  out  1  interrupt request to the CPU.
int_ack  in  1  CPU accepts the interrupt and reads int_vector.
int_done  in  1  CPU finished the service routine (return).
int_vector  out  8  vector of the selected source.
busy  out  1  high whenever state is not IDLE.

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high.
- Reset values (applied at the next clk edge, from any state, including mid-handshake): state=IDLE, irq=0, int_handled=0, int_vector=0, sel=0, busy=0.
- pending = int_request & mask. Priority is fixed: the lowest index wins.
- IDLE:
  - If pending is nonzero at edge N: latch the winner into sel, set int_vector=VEC_BASE+sel, set irq=1, go to REQUEST.
  - irq is therefore visible after edge N (one-cycle latency).
- REQUEST:
  - irq, sel and int_vector are held stable. There is no re-arbitration, even if a higher-priority source arrives or the selected request drops.
  - On int_ack: irq=0, int_handled[sel]=1 for exactly one cycle, go to SERVICE.
- SERVICE:
  - int_handled returns to 0 on the next edge.
  - Wait for int_done. On int_done, go to IDLE.
- Ignored inputs: int_ack outside REQUEST; int_done outside SERVICE. An int_done arriving in the same cycle as int_ack in REQUEST is ignored.
- Back-to-back: if int_done is sampled at edge N, state is IDLE after N, arbitration happens at N+1 and irq is high after N+1. This gives 2 idle irq cycles minimum.
- int_handled is strictly one-hot or zero and is driven only from a register, never combinationally.
- busy is combinational from state.

Optional Feature:
INT_MASK_EN
- Defined:
  - Adds ports mask_we (in, 1), mask_wdata (in, NUM_SRC) and mask_q (out, NUM_SRC).
  - The mask register resets to all ones and loads mask_wdata on a clk edge where mask_we=1.
  - The new mask affects arbitration from the following cycle.
  - Masking a source already latched in sel does not cancel its delivery.
- Undefined: the ports are absent and mask is constant all ones.

Decomposition:
- Shared package interrupt_pkg holds:
  - state encoding: IDLE=2'd0, REQUEST=2'd1, SERVICE=2'd2; 2'd3 decodes to IDLE.
  - defaults for NUM_SRC and VEC_BASE.
  - the index width constant (4 bits).
- One sub-module, prio_encoder: combinational, pending in -> valid and index out, lowest index first.

Test Plan:
1. Single source: request[3]=1 at edge 5 -> irq=1 after edge 5, int_vector=8'h23; int_ack at edge 8 -> int_handled=8'b0000_1000 for one cycle, irq=0; int_done at edge 12 -> busy=0.
2. Simultaneous requests on sources 5 and 1 -> vector 8'h21 is delivered first. After int_done, vector 8'h25 follows with irq rising exactly 2 cycles after int_done.
3. Source 0 asserts while in REQUEST for source 4 -> int_vector stays 8'h24. Source 0 is served in the next round.
4. int_ack pulsed in IDLE and int_done pulsed in REQUEST -> no state change, no int_handled pulse.
5. reset asserted in SERVICE with int_handled high -> all outputs are 0 after that edge. A still-high request is re-arbitrated after reset drops.
6. With INT_MASK_EN: mask_wdata=8'hFD with request[1]=1 -> no irq. Write 8'hFF -> irq rises 2 cycles later with vector 8'h21.
